// File: rtl/mips_prog_loader_if.sv
// Byte-stream and memory-write bundle between a boot image source and mips_prog_loader.
// master = image source / system side, slave = loader.
interface mips_prog_loader_if #(
    parameter int IA_W = 9,
    parameter int DA_W = 6
);
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            load_req;
    logic            imem_we;
    logic [IA_W-1:0] imem_addr;
    logic [31:0]     imem_wdata;
    logic            dmem_we;
    logic [DA_W-1:0] dmem_addr;
    logic [31:0]     dmem_wdata;
    logic            core_rst;
    logic            done;
    logic            error;

    modport master (
        output in_valid, in_data, load_req,
        input  in_ready, imem_we, imem_addr, imem_wdata,
               dmem_we, dmem_addr, dmem_wdata, core_rst, done, error
    );

    modport slave (
        input  in_valid, in_data, load_req,
        output in_ready, imem_we, imem_addr, imem_wdata,
               dmem_we, dmem_addr, dmem_wdata, core_rst, done, error
    );
endinterface

// File: rtl/mips_prog_loader.sv
// Boot loader: assembles big-endian words from a byte stream into MIPS imem/dmem, holding the core in reset.
// Optional trailing XOR checksum word enabled by defining LOADER_CHECKSUM_EN.
module mips_prog_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 64,
    parameter int IA_W       = $clog2(IMEM_DEPTH),
    parameter int DA_W       = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    mips_prog_loader_if.slave bus
);
    // state  | meaning
    // HDR_I  | capture instruction count N
    // HDR_D  | capture data count M
    // LOAD_I | write N words to imem
    // LOAD_D | write M words to dmem
    // CHK    | compare trailing checksum word (checksum build only)
    // RUN    | image loaded, core released
    // ERR    | malformed image, core held in reset
    typedef enum logic [2:0] {
        HDR_I,
        HDR_D,
        LOAD_I,
        LOAD_D,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        RUN,
        ERR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    state_t          w_tail;
    logic [1:0]      r_bcnt;
    logic [23:0]     r_shift;
    logic [IA_W:0]   r_n;
    logic [DA_W:0]   r_m;
    logic [IA_W-1:0] r_idx_i;
    logic [DA_W-1:0] r_idx_d;
    logic            r_imem_we;
    logic [IA_W-1:0] r_imem_addr;
    logic [31:0]     r_imem_wdata;
    logic            r_dmem_we;
    logic [DA_W-1:0] r_dmem_addr;
    logic [31:0]     r_dmem_wdata;
    logic            r_core_rst;
    logic            r_done;
    logic            r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]     r_csum;
`endif

    logic        w_ready;
    logic        w_fire;
    logic        w_wdone;
    logic        w_restart;
    logic        w_last_i;
    logic        w_last_d;
    logic [31:0] w_word;

    assign w_ready   = (r_state != RUN) && (r_state != ERR);
    assign w_fire    = bus.in_valid && w_ready;
    assign w_wdone   = w_fire && (r_bcnt == 2'd3);
    assign w_word    = {r_shift, bus.in_data};
    assign w_restart = bus.load_req && !w_ready;
    assign w_last_i  = ({1'b0, r_idx_i} == (r_n - (IA_W+1)'(1)));
    assign w_last_d  = ({1'b0, r_idx_d} == (r_m - (DA_W+1)'(1)));

`ifdef LOADER_CHECKSUM_EN
    assign w_tail = CHK;
`else
    assign w_tail = RUN;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= HDR_I;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            HDR_I: begin
                if (w_wdone) w_next = (w_word > 32'(IMEM_DEPTH)) ? ERR : HDR_D;
            end
            HDR_D: begin
                if (w_wdone) begin
                    if (w_word > 32'(DMEM_DEPTH)) w_next = ERR;
                    else if (r_n != '0)           w_next = LOAD_I;
                    else if (w_word != 32'd0)     w_next = LOAD_D;
                    else                          w_next = w_tail;
                end
            end
            LOAD_I: begin
                if (w_wdone && w_last_i) w_next = (r_m != '0) ? LOAD_D : w_tail;
            end
            LOAD_D: begin
                if (w_wdone && w_last_d) w_next = w_tail;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (w_wdone) w_next = (w_word == r_csum) ? RUN : ERR;
            end
`endif
            RUN, ERR: begin
                if (bus.load_req) w_next = HDR_I;
            end
            default: w_next = HDR_I;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt       <= '0;
            r_shift      <= '0;
            r_n          <= '0;
            r_m          <= '0;
            r_idx_i      <= '0;
            r_idx_d      <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_core_rst   <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_imem_we  <= 1'b0;
            r_dmem_we  <= 1'b0;
            // release lags RUN entry by one cycle so the final write strobe lands with the core still in reset
            r_core_rst <= !((r_state == RUN) && (w_next == RUN));
            r_done     <= (r_state == RUN) && (w_next == RUN);
            r_error    <= (w_next == ERR);
            if (w_restart) begin
                r_bcnt  <= '0;
                r_shift <= '0;
                r_idx_i <= '0;
                r_idx_d <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_csum  <= '0;
`endif
            end else if (w_fire) begin
                r_bcnt  <= r_bcnt + 2'd1;
                r_shift <= {r_shift[15:0], bus.in_data};
                if (r_bcnt == 2'd3) begin
`ifdef LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ w_word;
`endif
                    case (r_state)
                        HDR_I: r_n <= w_word[IA_W:0];
                        HDR_D: r_m <= w_word[DA_W:0];
                        LOAD_I: begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_idx_i;
                            r_imem_wdata <= w_word;
                            r_idx_i      <= r_idx_i + 1'b1;
                        end
                        LOAD_D: begin
                            r_dmem_we    <= 1'b1;
                            r_dmem_addr  <= r_idx_d;
                            r_dmem_wdata <= w_word;
                            r_idx_d      <= r_idx_d + 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.dmem_we    = r_dmem_we;
    assign bus.dmem_addr  = r_dmem_addr;
    assign bus.dmem_wdata = r_dmem_wdata;
    assign bus.core_rst   = r_core_rst;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: streams small images and checks writes, status and handshake.
module tb_mips_prog_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mips_prog_loader_if #(.IA_W(9), .DA_W(6)) bus();

    mips_prog_loader #(.IMEM_DEPTH(512), .DMEM_DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // write recorder, cleared while rst is high
    logic [31:0] wr_i [0:511];
    logic [31:0] wr_d [0:63];
    int          icyc [0:7];
    int          ni  = 0;
    int          nd  = 0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            ni = 0;
            nd = 0;
            for (int i = 0; i < 512; i++) wr_i[i] = 32'd0;
            for (int i = 0; i < 64; i++)  wr_d[i] = 32'd0;
        end else begin
            if (bus.imem_we === 1'b1) begin
                wr_i[bus.imem_addr] = bus.imem_wdata;
                if (ni < 8) icyc[ni] = cyc;
                ni = ni + 1;
            end
            if (bus.dmem_we === 1'b1) begin
                wr_d[bus.dmem_addr] = bus.dmem_wdata;
                nd = nd + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ready_at;
        ready_at = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int k = 0; k < 50; k++) begin
            ready_at = bus.in_ready;
            @(posedge clk);
            #1;
            if (ready_at) break;
        end
        bus.in_valid = 1'b0;
        check("byte_accept", 32'(ready_at), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            if (max_gap > 0) tick($urandom_range(0, max_gap));
            send_byte(w[31-8*i -: 8]);
        end
    endtask

    task automatic pulse_load_req();
        bus.load_req = 1'b1;
        tick(1);
        bus.load_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] partial;
        int          ni0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.load_req = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);

        // reset values
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_core_rst", 32'(bus.core_rst), 32'd1);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_error",    32'(bus.error),    32'd0);
        check("rst_imem_we",  32'(bus.imem_we),  32'd0);
        check("rst_dmem_we",  32'(bus.dmem_we),  32'd0);
        check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_imem_wdata", bus.imem_wdata,    32'd0);

        // gapless image N=2 M=1
        send_word(32'd2, 0);
        send_word(32'd1, 0);
        send_word(32'h00000820, 0);
        check("t1_we_i0",    32'(bus.imem_we),   32'd1);
        check("t1_addr_i0",  32'(bus.imem_addr), 32'd0);
        check("t1_wdata_i0", bus.imem_wdata,     32'h00000820);
        send_word(32'h20020024, 0);
        send_word(32'h0000000A, 0);
        check("t1_we_d0", 32'(bus.dmem_we), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd2 ^ 32'd1 ^ 32'h00000820 ^ 32'h20020024 ^ 32'h0000000A, 0);
`endif
        check("t1_done_early", 32'(bus.done), 32'd0);
        check("t1_crst_early", 32'(bus.core_rst), 32'd1);
        tick(1);
        check("t1_done",      32'(bus.done),     32'd1);
        check("t1_core_rst",  32'(bus.core_rst), 32'd0);
        check("t1_in_ready",  32'(bus.in_ready), 32'd0);
        check("t1_imem0",     wr_i[0], 32'h00000820);
        check("t1_imem1",     wr_i[1], 32'h20020024);
        check("t1_dmem0",     wr_d[0], 32'h0000000A);
        check("t1_n_iwr",     32'(ni), 32'd2);
        check("t1_n_dwr",     32'(nd), 32'd1);
        check("t1_we_spacing", 32'(icyc[1] - icyc[0]), 32'd4);

        // same image with random bubbles
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        send_word(32'd2, 2);
        send_word(32'd1, 2);
        partial = 32'h00000820;
        for (int i = 0; i < 3; i++) begin
            tick($urandom_range(0, 2));
            send_byte(partial[31-8*i -: 8]);
        end
        tick(3);
        check("t2_no_early_wr", 32'(ni), 32'd0);
        send_byte(partial[7:0]);
        check("t2_we_on_4th", 32'(bus.imem_we), 32'd1);
        send_word(32'h20020024, 3);
        send_word(32'h0000000A, 3);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd2 ^ 32'd1 ^ 32'h00000820 ^ 32'h20020024 ^ 32'h0000000A, 3);
`endif
        tick(1);
        check("t2_done",  32'(bus.done), 32'd1);
        check("t2_imem0", wr_i[0], 32'h00000820);
        check("t2_imem1", wr_i[1], 32'h20020024);
        check("t2_dmem0", wr_d[0], 32'h0000000A);
        check("t2_n_iwr", 32'(ni), 32'd2);

        // oversize instruction count
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        send_word(32'd513, 0);
        check("t3_error",    32'(bus.error),    32'd1);
        check("t3_in_ready", 32'(bus.in_ready), 32'd0);
        check("t3_core_rst", 32'(bus.core_rst), 32'd1);
        check("t3_imem_we",  32'(bus.imem_we),  32'd0);
        tick(2);
        check("t3_error_hold", 32'(bus.error), 32'd1);
        check("t3_n_iwr",      32'(ni),        32'd0);
        pulse_load_req();
        check("t3_err_clear", 32'(bus.error),    32'd0);
        check("t3_reload_rdy", 32'(bus.in_ready), 32'd1);

        // empty image
        send_word(32'd0, 0);
        send_word(32'd0, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd0, 0);
`endif
        tick(1);
        check("t4_done",     32'(bus.done),     32'd1);
        check("t4_core_rst", 32'(bus.core_rst), 32'd0);
        check("t4_no_wr",    32'(ni + nd),      32'd0);

        // reset in the middle of an instruction word, then a full reload
        pulse_load_req();
        check("t5_restart_crst", 32'(bus.core_rst), 32'd1);
        send_word(32'd2, 0);
        send_word(32'd1, 0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        #1;
        check("t5_async_crst",  32'(bus.core_rst), 32'd1);
        check("t5_async_ready", 32'(bus.in_ready), 32'd1);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("t5_ready",    32'(bus.in_ready), 32'd1);
        check("t5_done",     32'(bus.done),     32'd0);
        send_word(32'd1, 0);
        send_word(32'd2, 0);
        send_word(32'hDEADBEEF, 0);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd1 ^ 32'd2 ^ 32'hDEADBEEF ^ 32'h11223344 ^ 32'h55667788, 0);
`endif
        tick(1);
        check("t5_reload_done", 32'(bus.done), 32'd1);
        check("t5_imem0", wr_i[0], 32'hDEADBEEF);
        check("t5_dmem0", wr_d[0], 32'h11223344);
        check("t5_dmem1", wr_d[1], 32'h55667788);
        check("t5_n_dwr", 32'(nd), 32'd2);

        // load_req with a byte offered in RUN: byte must not be consumed
        ni0 = ni;
        bus.load_req = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        check("t6_run_not_ready", 32'(bus.in_ready), 32'd0);
        tick(1);
        bus.load_req = 1'b0;
        bus.in_valid = 1'b0;
        check("t6_core_rst", 32'(bus.core_rst), 32'd1);
        check("t6_done_clr", 32'(bus.done),     32'd0);
        check("t6_ready",    32'(bus.in_ready), 32'd1);
        send_word(32'd1, 0);
        send_word(32'd0, 0);
        send_word(32'h12345678, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd1 ^ 32'h12345678, 0);
`endif
        tick(1);
        check("t6_done",  32'(bus.done),  32'd1);
        check("t6_error", 32'(bus.error), 32'd0);
        check("t6_imem0", wr_i[0], 32'h12345678);
        check("t6_n_iwr", 32'(ni - ni0), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // wrong checksum
        pulse_load_req();
        send_word(32'd0, 0);
        send_word(32'd0, 0);
        send_word(32'h00000001, 0);
        check("t7_bad_csum_err",  32'(bus.error),    32'd1);
        check("t7_bad_csum_crst", 32'(bus.core_rst), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
